blackjack_round_ctrl: RTL and testbench

Sequences one blackjack round from the card source to both hands. It runs the initial deal, player hit/stand turns, the dealer draw rule, and the final result. Card ranks come from the RNG through a request/acknowledge handshake. Score and status outputs drive the 7-segment score displays and the dealing/game-over indicators.

---
 rtl/blackjack_round_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_blackjack_round_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_round_ctrl.sv
// blackjack_round_ctrl: runs one blackjack round, fetching cards from the RNG
// over a req/ack handshake and producing both scores and the result.
module blackjack_round_ctrl #(
  parameter int DEALER_STAND = 17,
  parameter int BUST_LIMIT   = 21
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       new_round,
  input  logic       hit,
  input  logic       stand,
  input  logic       card_ack,
  input  logic [3:0] card_rank,
  output logic       card_req,
  output logic [4:0] player_score,
  output logic [4:0] dealer_score,
  output logic       dealing_cards,
  output logic       game_finished,
  output logic [1:0] result
);

  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] DEAL_P1     = 4'd1;
  localparam logic [3:0] DEAL_D1     = 4'd2;
  localparam logic [3:0] DEAL_P2     = 4'd3;
  localparam logic [3:0] DEAL_D2     = 4'd4;
  localparam logic [3:0] PLAYER_TURN = 4'd5;
  localparam logic [3:0] PLAYER_HIT  = 4'd6;
  localparam logic [3:0] DEALER_TURN = 4'd7;
  localparam logic [3:0] DEALER_HIT  = 4'd8;
  localparam logic [3:0] RESOLVE     = 4'd9;
  localparam logic [3:0] DONE        = 4'd10;

  localparam logic [5:0] BUST6  = 6'(BUST_LIMIT);
  localparam logic [4:0] BUST5  = 5'(BUST_LIMIT);
  localparam logic [4:0] STAND5 = 5'(DEALER_STAND);

  logic [3:0] state;
  logic [3:0] state_nx;
  logic       player_soft;
  logic       dealer_soft;

  logic       card_ace;
  logic [4:0] card_val;
  logic       to_player;
  logic [4:0] hand_score;
  logic       hand_soft;
  logic       soft_in;
  logic [5:0] sum;
  logic [4:0] new_score;
  logic       new_soft;
  logic       start;
  logic       take_card;
  logic       player_bust;
  logic       dealer_bust;
  logic [1:0] res_calc;

  function automatic logic is_fetch(input logic [3:0] s);
    return (s == DEAL_P1) || (s == DEAL_D1) ||
           (s == DEAL_P2) || (s == DEAL_D2) ||
           (s == PLAYER_HIT) || (s == DEALER_HIT);
  endfunction

  assign card_ace = (card_rank == 4'd1);

  always_comb begin
    card_val = 5'd10;
    unique case (1'b1)
      card_ace: card_val = 5'd11;
      (card_rank >= 4'd2) && (card_rank <= 4'd10):
        card_val = {1'b0, card_rank};
      default: card_val = 5'd10;
    endcase
  end

  assign to_player = (state == DEAL_P1) ||
                     (state == DEAL_P2) ||
                     (state == PLAYER_HIT);

  assign hand_score = to_player ? player_score : dealer_score;
  assign hand_soft  = to_player ? player_soft : dealer_soft;
  assign soft_in    = hand_soft | card_ace;
  assign sum        = {1'b0, hand_score} + {1'b0, card_val};

  // A soft ace drops from 11 to 1 once, the first time the hand overflows
  always_comb begin
    new_score = sum[4:0];
    new_soft  = soft_in;
    if ((sum > BUST6) && soft_in) begin
      new_score = sum[4:0] - 5'd10;
      new_soft  = 1'b0;
    end
  end

  assign start = ((state == IDLE) || (state == DONE)) && new_round;
  assign take_card = is_fetch(state) && card_ack;

  assign player_bust = (player_score > BUST5);
  assign dealer_bust = (dealer_score > BUST5);

  always_comb begin
    if (player_bust)
      res_calc = 2'b10;
    else if (dealer_bust)
      res_calc = 2'b01;
    else if (player_score > dealer_score)
      res_calc = 2'b01;
    else if (player_score < dealer_score)
      res_calc = 2'b10;
    else
      res_calc = 2'b11;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE:
        if (new_round) state_nx = DEAL_P1;
      DEAL_P1:
        if (card_ack) state_nx = DEAL_D1;
      DEAL_D1:
        if (card_ack) state_nx = DEAL_P2;
      DEAL_P2:
        if (card_ack) state_nx = DEAL_D2;
      DEAL_D2:
        if (card_ack) state_nx = PLAYER_TURN;
      PLAYER_TURN: begin
        if (player_score >= BUST5)
          state_nx = player_bust ? RESOLVE : DEALER_TURN;
        else if (stand)
          state_nx = DEALER_TURN;
        else if (hit)
          state_nx = PLAYER_HIT;
      end
      PLAYER_HIT:
        if (card_ack) state_nx = PLAYER_TURN;
      DEALER_TURN:
        state_nx = (dealer_score < STAND5) ? DEALER_HIT : RESOLVE;
      DEALER_HIT:
        if (card_ack) state_nx = DEALER_TURN;
      RESOLVE:
        state_nx = DONE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      card_req      <= 1'b0;
      dealing_cards <= 1'b0;
      game_finished <= 1'b0;
      player_score  <= 5'd0;
      dealer_score  <= 5'd0;
      player_soft   <= 1'b0;
      dealer_soft   <= 1'b0;
      result        <= 2'b00;
    end else begin
      state         <= state_nx;
      card_req      <= is_fetch(state_nx);
      dealing_cards <= is_fetch(state_nx);
      game_finished <= (state_nx == DONE);
      if (start) begin
        player_score <= 5'd0;
        dealer_score <= 5'd0;
        player_soft  <= 1'b0;
        dealer_soft  <= 1'b0;
        result       <= 2'b00;
      end else if (take_card) begin
        if (to_player) begin
          player_score <= new_score;
          player_soft  <= new_soft;
        end else begin
          dealer_score <= new_score;
          dealer_soft  <= new_soft;
        end
      end
      if (state == RESOLVE)
        result <= res_calc;
    end
  end

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// tb_blackjack_round_ctrl: table of whole rounds checked through a
// scoreboard, plus hand-written fetch/reset/handshake corner cases.
module tb_blackjack_round_ctrl;

  logic       clk;
  logic       reset_n;
  logic       new_round;
  logic       hit;
  logic       stand;
  logic       card_ack;
  logic [3:0] card_rank;
  logic       card_req;
  logic [4:0] player_score;
  logic [4:0] dealer_score;
  logic       dealing_cards;
  logic       game_finished;
  logic [1:0] result;

  typedef struct {
    logic [31:0] cards;
    int          ncards;
    int          hits;
    bit          stand_on;
    int          lat;
    logic [4:0]  p;
    logic [4:0]  d;
    logic [1:0]  r;
  } vec_t;

  typedef struct {
    logic [4:0] p;
    logic [4:0] d;
    logic [1:0] r;
    int         n;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] deck[$];
  int         given;
  bit         auto_ack;
  int         tests;
  int         fails;
  vec_t       vecs[12];

  blackjack_round_ctrl dut (
    .CLOCK_50      (clk),
    .reset_n       (reset_n),
    .new_round     (new_round),
    .hit           (hit),
    .stand         (stand),
    .card_ack      (card_ack),
    .card_rank     (card_rank),
    .card_req      (card_req),
    .player_score  (player_score),
    .dealer_score  (dealer_score),
    .dealing_cards (dealing_cards),
    .game_finished (game_finished),
    .result        (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Card source: answers each requesting cycle from the deck queue
  initial begin
    card_ack  = 1'b0;
    card_rank = 4'd0;
    forever begin
      @(negedge clk);
      if (auto_ack) begin
        if (card_req && deck.size() > 0) begin
          card_rank = deck.pop_front();
          card_ack  = 1'b1;
          given++;
        end else begin
          card_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic pulse_new();
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  task automatic pulse_stand();
    stand = 1'b1;
    @(negedge clk);
    stand = 1'b0;
  endtask

  task automatic wait_player(input int n);
    int t;
    t = 0;
    while (t < 200 && !(given == n && !dealing_cards)) begin
      @(negedge clk);
      t++;
    end
    check("player_turn_reached",
          32'(given == n && !dealing_cards), 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (cyc < 200 && !game_finished) begin
      @(negedge clk);
      cyc++;
    end
    check("game_finished", 32'(game_finished), 32'd1);
  endtask

  task automatic load_deck(input logic [31:0] c,
                           input int n);
    given = 0;
    deck.delete();
    for (int i = 0; i < n; i++)
      deck.push_back(c[31-4*i -: 4]);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   cyc;
    load_deck(v.cards, v.ncards);
    e.p = v.p;
    e.d = v.d;
    e.r = v.r;
    e.n = v.ncards;
    sb.push_back(e);
    pulse_new();
    check($sformatf("v%0d_start_clear", idx),
          32'({game_finished, result}), 32'd0);
    for (int k = 0; k < v.hits; k++) begin
      wait_player(4 + k);
      pulse_hit();
    end
    if (v.stand_on) begin
      wait_player(4 + v.hits);
      pulse_stand();
    end
    wait_done(cyc);
    if (v.lat != 0)
      check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.lat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("v%0d_player", idx), 32'(player_score), 32'(e.p));
      check($sformatf("v%0d_dealer", idx), 32'(dealer_score), 32'(e.d));
      check($sformatf("v%0d_result", idx), 32'(result), 32'(e.r));
      check($sformatf("v%0d_cards", idx), 32'(given), 32'(e.n));
    end
  endtask

  initial begin
    int cyc;
    tests     = 0;
    fails     = 0;
    auto_ack  = 1'b1;
    given     = 0;
    new_round = 1'b0;
    hit       = 1'b0;
    stand     = 1'b0;

    // cards listed first-dealt in the top nibble
    vecs[0]  = '{32'hA79A0000, 4, 0, 1'b1, 3, 5'd19, 5'd17, 2'b01};
    vecs[1]  = '{32'h15166000, 5, 0, 1'b1, 5, 5'd12, 5'd17, 2'b10};
    vecs[2]  = '{32'hAA698000, 5, 1, 1'b0, 0, 5'd24, 5'd19, 2'b10};
    vecs[3]  = '{32'h19D80000, 4, 0, 1'b0, 0, 5'd21, 5'd17, 2'b01};
    vecs[4]  = '{32'hAAAA0000, 4, 0, 1'b1, 3, 5'd20, 5'd20, 2'b11};
    vecs[5]  = '{32'hA69AA000, 5, 0, 1'b1, 5, 5'd19, 5'd26, 2'b01};
    vecs[6]  = '{32'hA1860000, 4, 0, 1'b1, 3, 5'd18, 5'd17, 2'b01};
    vecs[7]  = '{32'h23451A50, 7, 3, 1'b0, 0, 5'd22, 5'd8,  2'b10};
    vecs[8]  = '{32'hAA790000, 4, 0, 1'b1, 3, 5'd17, 5'd19, 2'b10};
    vecs[9]  = '{32'h1A170000, 4, 0, 1'b1, 3, 5'd12, 5'd17, 2'b10};
    vecs[10] = '{32'h0FE2C000, 5, 0, 1'b1, 5, 5'd20, 5'd22, 2'b01};
    vecs[11] = '{32'h5A67A000, 5, 1, 1'b0, 0, 5'd21, 5'd17, 2'b01};

    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs",
          32'({card_req, dealing_cards, game_finished,
               result, player_score, dealer_score}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", 32'(card_req), 32'd0);

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i], i);

    // hit and stand together: stand wins, no card requested
    load_deck(32'hA79A0000, 4);
    pulse_new();
    wait_player(4);
    hit   = 1'b1;
    stand = 1'b1;
    @(negedge clk);
    hit   = 1'b0;
    stand = 1'b0;
    check("hs_no_req", 32'(card_req), 32'd0);
    @(negedge clk);
    check("hs_no_req2", 32'(card_req), 32'd0);
    wait_done(cyc);
    check("hs_result", 32'(result), 32'd1);
    check("hs_cards", 32'(given), 32'd4);

    // stray ack and new_round in PLAYER_TURN are ignored
    load_deck(32'hA79A0000, 4);
    pulse_new();
    wait_player(4);
    auto_ack  = 1'b0;
    card_rank = 4'd5;
    card_ack  = 1'b1;
    new_round = 1'b1;
    @(negedge clk);
    card_ack  = 1'b0;
    new_round = 1'b0;
    auto_ack  = 1'b1;
    check("stray_ack_player", 32'(player_score), 32'd19);
    check("stray_ack_dealer", 32'(dealer_score), 32'd17);
    check("stray_newround_req", 32'(card_req), 32'd0);
    pulse_stand();
    wait_done(cyc);
    check("stray_latency", 32'(cyc), 32'd3);
    check("stray_result", 32'(result), 32'd1);
    pulse_hit();
    check("hit_in_done_req", 32'(card_req), 32'd0);
    check("hit_in_done_hold",
          32'({game_finished, result}), 32'b101);

    // slow ack in DEAL_D1, then reset while still fetching
    auto_ack = 1'b0;
    deck.delete();
    pulse_new();
    card_rank = 4'd10;
    card_ack  = 1'b1;
    @(negedge clk);
    card_ack = 1'b0;
    check("slow_p1_score", 32'(player_score), 32'd10);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("slow_req_c%0d", i),
            32'({card_req, dealing_cards}), 32'b11);
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({card_req, dealing_cards, game_finished,
               result, player_score, dealer_score}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_idle",
          32'({card_req, dealing_cards, game_finished}), 32'd0);
    auto_ack = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
